// File: rtl/uart_tx_fifo_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and helpers for the UART TX FIFO write-port arbiter.
// Revision: 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;

  // Index width that stays at least one bit for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational rotating-priority picker (first set bit from ptr).
// Revision: 1.0
// ============================================================================
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                req,
  input  logic [clog2_min1(N)-1:0]    ptr,
  output logic                        any,
  output logic [clog2_min1(N)-1:0]    idx
);

  localparam int c_W = clog2_min1(N);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic           w_found;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign w_mask[gi] = (ptr <= c_W'(gi));
    end
  endgenerate

  // Low half holds requests at or above ptr; high half wraps around.
  assign w_dbl = {req, req & w_mask};

  always_comb begin
    any     = |req;
    idx     = '0;
    w_found = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (!w_found && w_dbl[j]) begin
        w_found = 1'b1;
        idx     = (j >= N) ? c_W'(j - N) : c_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo_arbiter
// Brief   : Round-robin, burst-locked arbiter sharing one TX FIFO write port.
// Revision: 1.0
// ============================================================================
module uart_tx_fifo_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int c_ID_W   = clog2_min1(NUM_REQ);
  localparam int c_BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(MAX_BURST - 1);
  localparam logic [c_ID_W-1:0]   c_LAST_ID   = c_ID_W'(NUM_REQ - 1);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [c_ID_W-1:0]       r_rr_ptr;
  logic [c_ID_W-1:0]       r_grant_id;
  logic [c_BEAT_W-1:0]     r_beat_cnt;
  logic                    r_wr_en;
  logic [DATA_WIDTH-1:0]   r_din;

  logic                    w_pick_any;
  logic [c_ID_W-1:0]       w_pick_idx;
  logic                    w_stall;
  logic                    w_accept;
  logic                    w_end;
  logic                    w_g_valid;
  logic                    w_g_last;
  logic [DATA_WIDTH-1:0]   w_g_data;
  logic [c_ID_W-1:0]       w_ptr_nxt;

  rr_pick #(
    .N   (NUM_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  assign w_g_valid = req_valid[r_grant_id];
  assign w_g_last  = req_last[r_grant_id];
  assign w_g_data  = req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign w_ptr_nxt = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;

  // The registered write still in flight counts against the last free slot.
  assign w_stall = fifo_full | (r_wr_en & fifo_almost_full);

  always_comb begin
    req_ready   = '0;
    w_accept    = 1'b0;
    w_end       = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) w_state_nxt = ARB_XFER;
      end
      ARB_XFER: begin
        req_ready[r_grant_id] = !w_stall;
        w_accept = !w_stall && w_g_valid;
        w_end    = w_accept && (w_g_last || (r_beat_cnt == c_LAST_BEAT));
        if (w_end) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_wr_en    <= 1'b0;
      r_din      <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_din      <= w_g_data;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_end) r_rr_ptr <= w_ptr_nxt;
      if (r_state == ARB_IDLE && w_pick_any) begin
        r_grant_id <= w_pick_idx;
        r_beat_cnt <= '0;
      end
    end
  end

  assign fifo_wr_en = r_wr_en;
  assign fifo_din   = r_din;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state == ARB_XFER);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo_arbiter
// Brief   : Directed self-checking bench for uart_tx_fifo_arbiter.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_fifo_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_almost_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [1:0]  grant_id;
  logic        busy;

  uart_tx_fifo_arbiter #(
    .NUM_REQ          (4),
    .DATA_WIDTH       (8),
    .MAX_BURST        (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_din         (fifo_din),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Per-requester beat stores: bit 8 is 'last', bits 7:0 the byte.
  logic [8:0] mem [4][64];
  int         head [4];
  int         tail [4];
  logic [3:0] gate;
  logic [3:0] acc;

  logic [7:0] wlog [64];
  int         wcyc [64];
  int         wn;
  logic [1:0] glog [32];
  int         gn;
  logic       prev_busy;
  int         cyc;

  logic       use_fifo;
  int         cnt;
  int         ovf;
  int         ready_full;
  logic       wr_pre;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_bench();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    gate       = 4'hF;
    wn         = 0;
    gn         = 0;
    use_fifo   = 1'b0;
    cnt        = 0;
    ovf        = 0;
    ready_full = 0;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][tail[r]] = {l, d};
    tail[r]++;
  endtask

  // One clock: drive at negedge, sample handshake just before posedge,
  // observe registered outputs at the following negedge.
  task automatic step();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = gate[i] && (head[i] < tail[i]);
      req_data[i*8 +: 8] = mem[i][head[i] & 63][7:0];
      req_last[i]        = mem[i][head[i] & 63][8];
    end
    fifo_full        = use_fifo && (cnt >= 16);
    fifo_almost_full = use_fifo && (cnt == 15);
    #1;
    acc    = req_valid & req_ready;
    wr_pre = fifo_wr_en;
    if (fifo_full && req_ready[0]) ready_full++;
    @(posedge clk);
    if (use_fifo && wr_pre) begin
      if (cnt >= 16) ovf++;
      cnt++;
    end
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) if (acc[i]) head[i]++;
    if (fifo_wr_en && wn < 64) begin
      wlog[wn] = fifo_din;
      wcyc[wn] = cyc;
      wn++;
    end
    if (busy && !prev_busy && gn < 32) begin
      glog[gn] = grant_id;
      gn++;
    end
    prev_busy = busy;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int k = 0; k < n; k++) step();
    reset = 1'b0;
    clear_bench();
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 64; k++) mem[i][k] = '0;
    cyc       = 0;
    prev_busy = 1'b0;
    clear_bench();
    @(negedge clk);

    // Test 1: reset then a 3-beat burst from requester 1
    do_reset(3);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_din", int'(fifo_din), 0);
    chk("rst_ready", int'(req_ready), 0);
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b1);
    step();
    chk("t1_ready_arb", int'(req_ready), 4'b0010);
    step(); step(); step();
    chk("t1_wn", wn, 3);
    chk("t1_busy_fall", int'(busy), 0);
    chk("t1_grant", int'(glog[0]), 1);
    chk("t1_w0", int'(wlog[0]), 8'hA1);
    chk("t1_w1", int'(wlog[1]), 8'hA2);
    chk("t1_w2", int'(wlog[2]), 8'hA3);
    chk("t1_consec", wcyc[2] - wcyc[0], 2);
    step();
    chk("t1_wr_drop", int'(fifo_wr_en), 0);

    // Test 2: round-robin with single-beat bursts on all requesters
    do_reset(2);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) push(i, 8'(k*16 + i), 1'b1);
    for (int k = 0; k < 20; k++) step();
    chk("t2_gn", gn, 8);
    chk("t2_wn", wn, 8);
    for (int k = 0; k < 8; k++) begin
      chk("t2_gorder", int'(glog[k]), k % 4);
      chk("t2_data", int'(wlog[k]), (k / 4) * 16 + (k % 4));
    end
    for (int k = 0; k < 7; k++) chk("t2_gap", wcyc[k+1] - wcyc[k], 2);

    // Test 3: burst cap at 16 beats, requester 3 served in between
    do_reset(2);
    for (int k = 0; k < 20; k++) push(2, 8'(8'h40 + k), 1'b0);
    push(3, 8'h77, 1'b1);
    for (int k = 0; k < 30; k++) step();
    chk("t3_wn", wn, 21);
    chk("t3_first", int'(wlog[0]), 8'h40);
    chk("t3_cap", int'(wlog[15]), 8'h4F);
    chk("t3_run", wcyc[15] - wcyc[0], 15);
    chk("t3_r3", int'(wlog[16]), 8'h77);
    chk("t3_resume", int'(wlog[17]), 8'h50);
    chk("t3_tail", int'(wlog[20]), 8'h53);
    chk("t3_gn", gn, 3);
    chk("t3_g0", int'(glog[0]), 2);
    chk("t3_g1", int'(glog[1]), 3);
    chk("t3_g2", int'(glog[2]), 2);
    chk("t3_hold", int'(busy), 1);

    // Test 4: backpressure from a depth-16 FIFO that is never read
    do_reset(2);
    use_fifo = 1'b1;
    for (int k = 0; k < 20; k++) push(0, 8'(8'h80 + k), k == 19);
    for (int k = 0; k < 40; k++) step();
    chk("t4_wn", wn, 16);
    chk("t4_cnt", cnt, 16);
    chk("t4_ovf", ovf, 0);
    chk("t4_ready_full", ready_full, 0);
    chk("t4_last", int'(wlog[15]), 8'h8F);
    chk("t4_ready_now", int'(req_ready), 0);

    // Test 5: valid gap mid-burst, requester 3 pending
    do_reset(2);
    for (int k = 0; k < 4; k++) push(1, 8'(8'h31 + k), k == 3);
    push(3, 8'h99, 1'b1);
    step(); step(); step();
    gate[1] = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("t5_gap_wn", wn, 2);
    chk("t5_gap_busy", int'(busy), 1);
    chk("t5_gap_grant", int'(grant_id), 1);
    gate[1] = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("t5_wn", wn, 5);
    chk("t5_w2", int'(wlog[2]), 8'h33);
    chk("t5_w3", int'(wlog[3]), 8'h34);
    chk("t5_w4", int'(wlog[4]), 8'h99);
    chk("t5_gn", gn, 2);
    chk("t5_g1", int'(glog[1]), 3);

    // Test 6: reset on beat 2 of 4, after rr_ptr has moved off zero
    do_reset(2);
    push(1, 8'h51, 1'b1);
    for (int k = 0; k < 4; k++) push(2, 8'(8'h61 + k), k == 3);
    step(); step(); step(); step();
    chk("t6_pre_grant", int'(grant_id), 2);
    chk("t6_pre_wn", wn, 2);
    reset = 1'b1;
    step();
    chk("t6_wr_en", int'(fifo_wr_en), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_grant", int'(grant_id), 0);
    reset = 1'b0;
    clear_bench();
    push(3, 8'h73, 1'b1);
    push(0, 8'h70, 1'b1);
    for (int k = 0; k < 6; k++) step();
    chk("t6_gn", gn, 2);
    chk("t6_restart", int'(glog[0]), 0);
    chk("t6_next", int'(glog[1]), 3);
    chk("t6_w0", int'(wlog[0]), 8'h70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
